// File: rtl/ecc_ctrl_pkg.sv
// Shared types and SECDED helpers for the ECC op sequencer.
// Codewords are held right-aligned in MAX_CW-bit words; bit i is Hamming position i+1.
package ecc_ctrl_pkg;

  localparam int unsigned MAX_CW = 32;

  typedef enum logic [1:0] {
    OP_ENC  = 2'd0,
    OP_DEC  = 2'd1,
    OP_FULL = 2'd2,
    OP_INV  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    CW_8   = 2'd0,
    CW_16  = 2'd1,
    CW_32  = 2'd2,
    CW_INV = 2'd3
  } cw_width_e;

  typedef struct packed {
    op_e               op;
    cw_width_e         w;
    logic [MAX_CW-1:0] data;
    logic [MAX_CW-1:0] noise;
  } cmd_t;

  function automatic int unsigned cw_bits(input cw_width_e w);
    case (w)
      CW_8:    return 8;
      CW_16:   return 16;
      CW_32:   return 32;
      default: return 0;
    endcase
  endfunction

  function automatic logic [MAX_CW-1:0] cw_mask(input int unsigned bits);
    return (bits >= MAX_CW) ? '1 : MAX_CW'((32'd1 << bits) - 32'd1);
  endfunction

  function automatic logic is_pow2(input int unsigned pos);
    return (pos & (pos - 32'd1)) == 32'd0;
  endfunction

  function automatic logic [MAX_CW-1:0] hamming_encode(input logic [MAX_CW-1:0] data,
                                                       input int unsigned bits);
    logic [MAX_CW-1:0] cw;
    int unsigned       k;
    logic              par;
    cw = '0;
    k  = 0;
    for (int unsigned pos = 1; pos < MAX_CW; pos++) begin
      if (pos < bits && !is_pow2(pos)) begin
        cw[5'(pos - 1)] = data[5'(k)];
        k++;
      end
    end
    // Each parity bit covers the positions whose index has that bit set.
    for (int unsigned b = 0; b < 5; b++) begin
      par = 1'b0;
      for (int unsigned pos = 1; pos < MAX_CW; pos++) begin
        if (pos < bits && (pos & (32'd1 << b)) != 0) par = par ^ cw[5'(pos - 1)];
      end
      if ((32'd1 << b) < bits) cw[5'((32'd1 << b) - 1)] = par;
    end
    cw[5'(bits - 1)] = ^(cw & cw_mask(bits - 1));
    return cw;
  endfunction

  function automatic logic [4:0] hamming_syndrome(input logic [MAX_CW-1:0] cw,
                                                  input int unsigned bits);
    logic [4:0] s;
    s = '0;
    for (int unsigned pos = 1; pos < MAX_CW; pos++) begin
      if (pos < bits && cw[5'(pos - 1)]) s = s ^ 5'(pos);
    end
    return s;
  endfunction

  function automatic logic [MAX_CW-1:0] extract_data(input logic [MAX_CW-1:0] cw,
                                                     input int unsigned bits);
    logic [MAX_CW-1:0] d;
    int unsigned       k;
    d = '0;
    k = 0;
    for (int unsigned pos = 1; pos < MAX_CW; pos++) begin
      if (pos < bits && !is_pow2(pos)) begin
        d[5'(k)] = cw[5'(pos - 1)];
        k++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/ecc_cmd_fifo.sv
// Synchronous command FIFO; writes to a full queue and reads of an empty one are ignored.
module ecc_cmd_fifo
  import ecc_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  cmd_t                     i_wdata,
  input  logic                     i_pop,
  output cmd_t                     o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ecc_op_sequencer.sv
// Queued SECDED encode/decode/full-channel sequencer.
// Commands are popped one at a time from ecc_cmd_fifo and run through IDLE/ENC/DEC.
module ecc_op_sequencer
  import ecc_ctrl_pkg::*;
#(
  parameter int unsigned AMBA_WORD  = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AMBA_WORD-1:0]  CTRL,
  input  logic [AMBA_WORD-1:0]  DATA_IN,
  input  logic [AMBA_WORD-1:0]  CODEWORD_WIDTH,
  input  logic [AMBA_WORD-1:0]  NOISE,
  input  logic                  CTRL_ready,
  output logic                  cmd_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  operation_done,
  output logic [1:0]            num_of_errors,
  output logic                  op_error
);

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_DEC} state_e;

  state_e                   r_state, w_state_nxt;
  cmd_t                     w_push_cmd, w_head;
  logic                     w_full, w_empty, w_pop;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic                     w_unused;

  op_e                      r_op, w_op_nxt;
  logic [5:0]               r_bits, w_bits_nxt;
  logic [MAX_CW-1:0]        r_cw, w_cw_nxt;
  logic [MAX_CW-1:0]        r_noise, w_noise_nxt;
  logic                     r_done, w_done_nxt;
  logic                     r_err, w_err_nxt;
  logic [1:0]               r_nerr, w_nerr_nxt;
  logic [DATA_WIDTH-1:0]    r_dout, w_dout_nxt;

  int unsigned              w_head_bits, w_bits;
  logic                     w_head_bad;
  logic [MAX_CW-1:0]        w_enc, w_fixed, w_ext_raw, w_ext_fix;
  logic [4:0]               w_syn, w_flip_idx;
  logic                     w_par;

  assign w_push_cmd = '{op:    op_e'(CTRL[1:0]),
                        w:     cw_width_e'(CODEWORD_WIDTH[1:0]),
                        data:  MAX_CW'(DATA_IN),
                        noise: MAX_CW'(NOISE)};
  assign w_unused   = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2], w_count};

  ecc_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (CTRL_ready),
    .i_wdata (w_push_cmd),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign cmd_ready      = !w_full;
  assign data_out       = r_dout;
  assign operation_done = r_done;
  assign num_of_errors  = r_nerr;
  assign op_error       = r_err;

  // Head-of-queue validation and the SECDED datapath on the op registers.
  assign w_head_bits = cw_bits(w_head.w);
  assign w_head_bad  = (w_head.op == OP_INV) || (w_head_bits == 0) || (w_head_bits > DATA_WIDTH);
  assign w_bits      = 32'(r_bits);
  assign w_enc       = hamming_encode(r_cw, w_bits);
  assign w_syn       = hamming_syndrome(r_cw, w_bits);
  assign w_par       = ^r_cw;
  assign w_flip_idx  = (w_syn == '0) ? 5'(w_bits - 1) : (w_syn - 5'd1);
  assign w_fixed     = r_cw ^ (MAX_CW'(1) << w_flip_idx);
  assign w_ext_raw   = extract_data(r_cw, w_bits);
  assign w_ext_fix   = extract_data(w_fixed, w_bits);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_ENC;
      r_bits  <= '0;
      r_cw    <= '0;
      r_noise <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_nerr  <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_bits  <= w_bits_nxt;
      r_cw    <= w_cw_nxt;
      r_noise <= w_noise_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_nerr  <= w_nerr_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_op_nxt    = r_op;
    w_bits_nxt  = r_bits;
    w_cw_nxt    = r_cw;
    w_noise_nxt = r_noise;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_nerr_nxt  = r_nerr;
    w_dout_nxt  = r_dout;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_bad) begin
            w_done_nxt = 1'b1;
            w_err_nxt  = 1'b1;
            w_nerr_nxt = 2'd0;
            w_dout_nxt = '0;
          end else begin
            w_op_nxt    = w_head.op;
            w_bits_nxt  = 6'(w_head_bits);
            w_cw_nxt    = w_head.data & cw_mask(w_head_bits);
            w_noise_nxt = w_head.noise & cw_mask(w_head_bits);
            w_state_nxt = (w_head.op == OP_DEC) ? S_DEC : S_ENC;
          end
        end
      end
      S_ENC: begin
        if (r_op == OP_FULL) begin
          w_cw_nxt    = w_enc ^ r_noise;
          w_state_nxt = S_DEC;
        end else begin
          w_done_nxt  = 1'b1;
          w_nerr_nxt  = 2'd0;
          w_dout_nxt  = DATA_WIDTH'(w_enc);
          w_state_nxt = S_IDLE;
        end
      end
      S_DEC: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
        w_dout_nxt  = DATA_WIDTH'(w_ext_raw);
        // Odd overall parity means a single error unless the syndrome points outside the word.
        if (w_par) begin
          if (32'(w_syn) > w_bits - 1) begin
            w_nerr_nxt = 2'd2;
          end else begin
            w_nerr_nxt = 2'd1;
            w_dout_nxt = DATA_WIDTH'(w_ext_fix);
          end
        end else if (w_syn != '0) begin
          w_nerr_nxt = 2'd2;
        end else begin
          w_nerr_nxt = 2'd0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ecc_op_sequencer.sv
// Self-checking bench for ecc_op_sequencer: directed vector table, corner sequences,
// and randomized commands scored against a behavioural SECDED model.
module tb_ecc_op_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] CTRL, DATA_IN, CODEWORD_WIDTH, NOISE;
  logic        CTRL_ready;
  logic        cmd_ready;
  logic [31:0] data_out;
  logic        operation_done;
  logic [1:0]  num_of_errors;
  logic        op_error;

  ecc_op_sequencer #(.AMBA_WORD(32), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .CTRL           (CTRL),
    .DATA_IN        (DATA_IN),
    .CODEWORD_WIDTH (CODEWORD_WIDTH),
    .NOISE          (NOISE),
    .CTRL_ready     (CTRL_ready),
    .cmd_ready      (cmd_ready),
    .data_out       (data_out),
    .operation_done (operation_done),
    .num_of_errors  (num_of_errors),
    .op_error       (op_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dout;
    logic [1:0]  nerr;
    logic        err;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  wc;
    logic [31:0] data;
    logic [31:0] noise;
    logic [31:0] dout;
    logic [1:0]  nerr;
    logic        err;
    int          lat;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  int   n_done = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: place data, then set parity bits so the syndrome becomes zero.
  function automatic logic [31:0] m_mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic bit m_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic logic [31:0] m_encode(input logic [31:0] d, input int w);
    logic [31:0] cw;
    int k, s;
    cw = 0; k = 0; s = 0;
    for (int pos = 1; pos < w; pos++)
      if (!m_pow2(pos)) begin cw[pos-1] = d[k]; k++; end
    for (int pos = 1; pos < w; pos++)
      if (cw[pos-1]) s ^= pos;
    for (int b = 0; b < 5; b++)
      if (s[b]) cw[(1 << b) - 1] = 1'b1;
    cw[w-1] = ^cw;
    return cw;
  endfunction

  function automatic logic [31:0] m_extract(input logic [31:0] cw, input int w);
    logic [31:0] d;
    int k;
    d = 0; k = 0;
    for (int pos = 1; pos < w; pos++)
      if (!m_pow2(pos)) begin d[k] = cw[pos-1]; k++; end
    return d;
  endfunction

  function automatic exp_t m_decode(input logic [31:0] cw, input int w);
    exp_t r;
    int s;
    bit p;
    s = 0;
    for (int pos = 1; pos < w; pos++)
      if (cw[pos-1]) s ^= pos;
    p = ^(cw & m_mask(w));
    r.err = 1'b0;
    if (p && s <= w - 1) begin
      cw[(s == 0) ? w - 1 : s - 1] ^= 1'b1;
      r.nerr = 2'd1;
    end else if (p || s != 0) begin
      r.nerr = 2'd2;
    end else begin
      r.nerr = 2'd0;
    end
    r.dout = m_extract(cw, w);
    return r;
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [1:0] wc,
                                 input logic [31:0] data, input logic [31:0] noise);
    exp_t r;
    int w;
    if (op == 2'd3 || wc == 2'd3) begin
      r.dout = 0; r.nerr = 0; r.err = 1'b1;
      return r;
    end
    w = 8 << wc;
    if (op == 2'd0) begin
      r.dout = m_encode(data, w); r.nerr = 0; r.err = 1'b0;
    end else if (op == 2'd1) begin
      r = m_decode(data & m_mask(w), w);
    end else begin
      r = m_decode(m_encode(data, w) ^ (noise & m_mask(w)), w);
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_err(input int w, input int n);
    logic [31:0] m;
    m = 0;
    while ($countones(m) < n) m |= 32'd1 << $urandom_range(w - 1, 0);
    return m;
  endfunction

  always @(posedge clk) begin
    #1;
    if (mon_en && operation_done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected_done: got done data_out=0x%0h, expected no done", data_out);
      end else begin
        mon_e = sb.pop_front();
        check("sb_dout", data_out, mon_e.dout);
        check("sb_nerr", 32'(num_of_errors), 32'(mon_e.nerr));
        check("sb_err", 32'(op_error), 32'(mon_e.err));
      end
    end
  end

  task automatic run_one(input vec_t v, input int idx);
    int cnt;
    CTRL = 32'(v.op); CODEWORD_WIDTH = 32'(v.wc); DATA_IN = v.data; NOISE = v.noise;
    CTRL_ready = 1'b1;
    tick();
    CTRL_ready = 1'b0;
    cnt = 0;
    do begin tick(); cnt++; end while (!operation_done && cnt < 10);
    check($sformatf("vec%0d_lat", idx), 32'(cnt), 32'(v.lat));
    check($sformatf("vec%0d_dout", idx), data_out, v.dout);
    check($sformatf("vec%0d_nerr", idx), 32'(num_of_errors), 32'(v.nerr));
    check($sformatf("vec%0d_err", idx), 32'(op_error), 32'(v.err));
    tick();
    check($sformatf("vec%0d_strobe", idx), 32'(operation_done), 32'd0);
    check($sformatf("vec%0d_hold", idx), data_out, v.dout);
  endtask

  task automatic drain(input string nm);
    int cnt;
    cnt = 0;
    while (sb.size() != 0 && cnt < 500) begin tick(); cnt++; end
    check(nm, 32'(sb.size()), 32'd0);
    repeat (5) tick();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  int          accepted, done0, gap, w;
  bit          saw_full, any_done;
  logic [1:0]  op, wc;
  logic [31:0] dat, nz;

  initial begin
    vecs[0]  = '{2'd0, 2'd0, 32'h0B,  32'h0,   32'h55, 2'd0, 1'b0, 2};
    vecs[1]  = '{2'd0, 2'd0, 32'h0F,  32'h0,   32'hFF, 2'd0, 1'b0, 2};
    vecs[2]  = '{2'd1, 2'd0, 32'h51,  32'h0,   32'h0B, 2'd1, 1'b0, 2};
    vecs[3]  = '{2'd1, 2'd0, 32'h50,  32'h0,   32'h0A, 2'd2, 1'b0, 2};
    vecs[4]  = '{2'd2, 2'd0, 32'h0B,  32'h80,  32'h0B, 2'd1, 1'b0, 3};
    vecs[5]  = '{2'd3, 2'd0, 32'h0B,  32'h0,   32'h00, 2'd0, 1'b1, 1};
    vecs[6]  = '{2'd0, 2'd0, 32'h1B,  32'h0,   32'h55, 2'd0, 1'b0, 2};
    vecs[7]  = '{2'd0, 2'd3, 32'h0B,  32'h0,   32'h00, 2'd0, 1'b1, 1};
    vecs[8]  = '{2'd1, 2'd0, 32'h155, 32'h0,   32'h0B, 2'd0, 1'b0, 2};
    vecs[9]  = '{2'd2, 2'd0, 32'h0B,  32'h03,  32'h0B, 2'd2, 1'b0, 3};
    vecs[10] = '{2'd2, 2'd0, 32'h0B,  32'hF00, 32'h0B, 2'd0, 1'b0, 3};
    vecs[11] = '{2'd1, 2'd0, 32'h55,  32'h0,   32'h0B, 2'd0, 1'b0, 2};

    reset = 1'b1; CTRL_ready = 1'b0;
    CTRL = 0; DATA_IN = 0; CODEWORD_WIDTH = 0; NOISE = 0;
    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(operation_done), 32'd0);
    check("rst_dout", data_out, 32'd0);
    check("rst_nerr", 32'(num_of_errors), 32'd0);
    check("rst_err", 32'(op_error), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run_one(vecs[i], i);

    // Back-to-back full-channel pushes overrun the queue; dropped ones must not run.
    mon_en = 1'b1;
    accepted = 0; saw_full = 1'b0; done0 = n_done;
    for (int i = 0; i < 10; i++) begin
      CTRL = 32'd2; CODEWORD_WIDTH = 32'd0; DATA_IN = 32'(i); NOISE = 32'd1 << (i % 8);
      CTRL_ready = 1'b1;
      if (cmd_ready) begin
        sb.push_back(model(2'd2, 2'd0, DATA_IN, NOISE));
        accepted++;
      end else begin
        saw_full = 1'b1;
      end
      tick();
    end
    CTRL_ready = 1'b0;
    drain("burst_drain");
    check("burst_saw_full", 32'(saw_full), 32'd1);
    check("burst_dropped", 32'(accepted < 10), 32'd1);
    check("burst_done_count", 32'(n_done - done0), 32'(accepted));
    mon_en = 1'b0;

    // Reset while a full-channel op sits in DEC with two commands queued.
    CTRL = 32'd2; CODEWORD_WIDTH = 0; DATA_IN = 32'h0B; NOISE = 32'h0; CTRL_ready = 1'b1;
    tick();
    CTRL = 32'd1; DATA_IN = 32'h55;
    tick();
    tick();
    CTRL_ready = 1'b0;
    reset = 1'b1;
    tick();
    check("rstmid_done", 32'(operation_done), 32'd0);
    check("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    reset = 1'b0;
    any_done = 1'b0;
    repeat (6) begin tick(); if (operation_done) any_done = 1'b1; end
    check("rstmid_queue_empty", 32'(any_done), 32'd0);
    check("rstmid_dout", data_out, 32'd0);
    run_one(vecs[0], 100);

    // Randomized mix against the model, with random gaps and junk in unused bits.
    mon_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      case ($urandom_range(0, 9))
        0, 1, 2: op = 2'd0;
        3, 4, 5: op = 2'd1;
        6, 7, 8: op = 2'd2;
        default: op = 2'd3;
      endcase
      wc = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      w = 8 << ((wc == 2'd3) ? 0 : wc);
      dat = $urandom();
      nz = $urandom();
      if (op == 2'd1)
        dat = (m_encode(dat, w) ^ rand_err(w, $urandom_range(0, 2))) | (dat & ~m_mask(w));
      if (op == 2'd2)
        nz = rand_err(w, $urandom_range(0, 2)) | (nz & ~m_mask(w));
      CTRL = ($urandom() & 32'hFFFF_FFFC) | 32'(op);
      CODEWORD_WIDTH = ($urandom() & 32'hFFFF_FFFC) | 32'(wc);
      DATA_IN = dat; NOISE = nz;
      CTRL_ready = 1'b1;
      if (cmd_ready) sb.push_back(model(op, wc, dat, nz));
      tick();
      CTRL_ready = 1'b0;
    end
    drain("rand_drain");
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
